// File: rtl/uart_tx_fifo.sv
// UART transmitter with a transmit FIFO and an internal baud divider. Frames are 5-9 data bits,
// optional parity and 1/1.5/2 stop bits. Break holds the line low.
module uart_tx_fifo #(
  parameter int unsigned DATA_W_MAX = 9,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DIV_W      = 16
) (
  input  logic                          i_u_clk,
  input  logic                          i_u_rst_n,
  input  logic [DIV_W-1:0]              i_clk_div,
  input  logic [3:0]                    i_data_bit,
  input  logic [1:0]                    i_stop_bit,
  input  logic [2:0]                    i_check_bit,
  input  logic                          i_break,
  input  logic [DATA_W_MAX-1:0]         i_uart_tx_data,
  input  logic                          i_uart_tx_valid,
  output logic                          o_uart_tx_ready,
  output logic                          o_uart_tx,
  output logic                          o_busy,
  output logic                          o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  // One extra bit so a two-stop-bit count of 2*D fits.
  localparam int unsigned CW = DIV_W + 1;

  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;

  // ---------------- FIFO ----------------
  logic [DATA_W_MAX-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [AW:0]           level_q;
  logic                  push, pop, fifo_empty, fifo_full;
  logic [DATA_W_MAX-1:0] rd_data;

  assign fifo_full       = (level_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty      = (level_q == '0);
  assign push            = i_uart_tx_valid && !fifo_full;
  assign rd_data         = mem_q[rd_ptr_q];
  assign o_uart_tx_ready = !fifo_full;
  assign o_fifo_level    = level_q;

  always_ff @(posedge i_u_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_uart_tx_data;
  end

  always_ff @(posedge i_u_clk or negedge i_u_rst_n) begin
    if (!i_u_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + (AW+1)'(1);
        2'b01:   level_q <= level_q - (AW+1)'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // ---------------- Frame configuration, sampled at frame start ----------------
  logic [CW-1:0]         div_eff, stop_m1;
  logic [3:0]            nbits_eff;
  logic [DATA_W_MAX-1:0] masked;
  logic                  par_en_cfg, par_bit_cfg;

  always_comb begin
    div_eff = (i_clk_div < DIV_W'(2)) ? CW'(2) : CW'(i_clk_div);
    if (i_data_bit < 4'd5)                    nbits_eff = 4'd5;
    else if (i_data_bit > 4'(DATA_W_MAX))     nbits_eff = 4'(DATA_W_MAX);
    else                                      nbits_eff = i_data_bit;
    masked = '0;
    for (int unsigned i = 0; i < DATA_W_MAX; i++) begin
      masked[i] = rd_data[i] && (i < 32'(nbits_eff));
    end
    par_en_cfg  = (i_check_bit >= 3'd1) && (i_check_bit <= 3'd4);
    par_bit_cfg = 1'b0;
    unique case (i_check_bit)
      3'd1:    par_bit_cfg = ~^masked;
      3'd2:    par_bit_cfg = ^masked;
      3'd3:    par_bit_cfg = 1'b1;
      default: par_bit_cfg = 1'b0;
    endcase
    unique case (i_stop_bit)
      2'd0:    stop_m1 = div_eff - CW'(1);
      2'd1:    stop_m1 = div_eff + (div_eff >> 1) - CW'(1);
      default: stop_m1 = (div_eff << 1) - CW'(1);
    endcase
  end

  // ---------------- Serialiser FSM ----------------
  state_e                state_q;
  logic [CW-1:0]         cnt_q, div_q, stop_m1_q;
  logic [3:0]            nbits_q, bits_left_q;
  logic [DATA_W_MAX-1:0] shift_q;
  logic                  par_en_q, par_bit_q, brk_rel_q;
  logic                  tx_q, busy_q, done_q;

  // A frame starts from IDLE, or directly off the last stop cycle for gapless back-to-back frames.
  always_comb begin
    pop = 1'b0;
    unique case (state_q)
      StIdle:  pop = !fifo_empty && !i_break;
      StStop:  pop = (cnt_q == '0) && !fifo_empty && !i_break;
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge i_u_clk or negedge i_u_rst_n) begin
    if (!i_u_rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      div_q       <= CW'(2);
      stop_m1_q   <= '0;
      nbits_q     <= 4'd8;
      bits_left_q <= '0;
      shift_q     <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      brk_rel_q   <= 1'b0;
      tx_q        <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= (state_q == StStop) && (cnt_q == '0);
      if (pop) begin
        state_q   <= StStart;
        tx_q      <= 1'b0;
        busy_q    <= 1'b1;
        cnt_q     <= div_eff - CW'(1);
        div_q     <= div_eff;
        nbits_q   <= nbits_eff;
        stop_m1_q <= stop_m1;
        par_en_q  <= par_en_cfg;
        par_bit_q <= par_bit_cfg;
        shift_q   <= masked;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (i_break) begin
              state_q   <= StBreak;
              tx_q      <= 1'b0;
              busy_q    <= 1'b1;
              div_q     <= div_eff;
              brk_rel_q <= 1'b0;
            end
          end
          StStart: begin
            if (cnt_q == '0) begin
              state_q     <= StData;
              tx_q        <= shift_q[0];
              shift_q     <= shift_q >> 1;
              bits_left_q <= nbits_q - 4'd1;
              cnt_q       <= div_q - CW'(1);
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          StData: begin
            if (cnt_q == '0) begin
              cnt_q <= div_q - CW'(1);
              if (bits_left_q != '0) begin
                tx_q        <= shift_q[0];
                shift_q     <= shift_q >> 1;
                bits_left_q <= bits_left_q - 4'd1;
              end else if (par_en_q) begin
                state_q <= StParity;
                tx_q    <= par_bit_q;
              end else begin
                state_q <= StStop;
                tx_q    <= 1'b1;
                cnt_q   <= stop_m1_q;
              end
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          StParity: begin
            if (cnt_q == '0) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
              cnt_q   <= stop_m1_q;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          StStop: begin
            if (cnt_q == '0) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          StBreak: begin
            // After release, hold a one-bit-period mark so the receiver can resynchronise.
            if (!brk_rel_q) begin
              if (!i_break) begin
                brk_rel_q <= 1'b1;
                tx_q      <= 1'b1;
                cnt_q     <= div_q - CW'(1);
              end
            end else if (cnt_q == '0) begin
              state_q <= StIdle;
              busy_q  <= 1'b0;
            end else begin
              cnt_q <= cnt_q - CW'(1);
            end
          end
          default: begin
            state_q <= StIdle;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_uart_tx = tx_q;
  assign o_busy    = busy_q;
  assign o_tx_done = done_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: accepted words queue an expected frame; a line monitor
// compares every serial cycle against a frame model built from the frame rules.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] clk_div;
  logic [3:0]  data_bit;
  logic [1:0]  stop_bit;
  logic [2:0]  check_bit;
  logic        brk, valid;
  logic [8:0]  tx_data;
  logic        ready, line, busy, done;
  logic [3:0]  level;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_W_MAX(9), .FIFO_DEPTH(8), .DIV_W(16)) dut (
    .i_u_clk        (clk),
    .i_u_rst_n      (rst_n),
    .i_clk_div      (clk_div),
    .i_data_bit     (data_bit),
    .i_stop_bit     (stop_bit),
    .i_check_bit    (check_bit),
    .i_break        (brk),
    .i_uart_tx_data (tx_data),
    .i_uart_tx_valid(valid),
    .o_uart_tx_ready(ready),
    .o_uart_tx      (line),
    .o_busy         (busy),
    .o_tx_done      (done),
    .o_fifo_level   (level)
  );

  typedef struct {
    int data;
    int d;
    int n;
    int stop;
    int pmode;
  } frame_t;

  frame_t sb[$];
  int checks = 0, errors = 0;
  int done_cnt = 0, contig = 0;
  bit mon_busy = 1'b0, mon_break = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int stop_len(frame_t f);
    case (f.stop)
      0:       return f.d;
      1:       return f.d + f.d / 2;
      default: return 2 * f.d;
    endcase
  endfunction

  // -1 when the frame carries no parity bit
  function automatic int par_val(frame_t f);
    int ones = 0;
    for (int i = 0; i < f.n; i++) ones += (f.data >> i) & 1;
    case (f.pmode)
      1:       return (ones % 2 == 0) ? 1 : 0;
      2:       return ones % 2;
      3:       return 1;
      4:       return 0;
      default: return -1;
    endcase
  endfunction

  function automatic int frame_len(frame_t f);
    return f.d * (1 + f.n + ((par_val(f) >= 0) ? 1 : 0)) + stop_len(f);
  endfunction

  function automatic logic exp_lvl(frame_t f, int k);
    int idx;
    if (k < f.d) return 1'b0;
    idx = k / f.d - 1;
    if (idx < f.n) return ((f.data >> idx) & 1) != 0;
    if (idx == f.n && par_val(f) >= 0) return par_val(f) != 0;
    return 1'b1;
  endfunction

  // Line monitor, sampled on the falling edge.
  initial begin : monitor
    frame_t cur;
    int k, len, bad;
    bit stray;
    k = 0; len = 0; bad = 0; stray = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        mon_busy = 1'b0;
        continue;
      end
      if (done === 1'b1) done_cnt++;
      if (mon_busy) begin
        if (k < len) begin
          if (line !== exp_lvl(cur, k) || (k > 0 && done !== 1'b0)) bad++;
          k++;
        end else begin
          check("frame_wave", bad, 0);
          check("tx_done_pulse", int'(done), 1);
          mon_busy = 1'b0;
          if (line === 1'b0 && !mon_break) contig++;
        end
      end
      if (line === 1'b1) stray = 1'b0;
      if (!mon_busy && !stray && line === 1'b0 && !mon_break) begin
        check("frame_expected", int'(sb.size() > 0), 1);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          len = frame_len(cur);
          k = 1;
          bad = 0;
          mon_busy = 1'b1;
        end else begin
          stray = 1'b1;
        end
      end
    end
  end

  task automatic set_cfg(input int dv, input int nb, input int sb_i, input int ck);
    clk_div = 16'(dv); data_bit = 4'(nb); stop_bit = 2'(sb_i); check_bit = 3'(ck);
  endtask

  task automatic push(input int data);
    frame_t f;
    int n = 0;
    valid = 1'b1;
    tx_data = data[8:0];
    while (ready !== 1'b1 && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check("push_ready", int'(ready), 1);
    f.data  = data & 'h1ff;
    f.d     = (int'(clk_div) < 2) ? 2 : int'(clk_div);
    f.n     = (int'(data_bit) < 5) ? 5 : ((int'(data_bit) > 9) ? 9 : int'(data_bit));
    f.stop  = int'(stop_bit);
    f.pmode = (check_bit >= 3'd1 && check_bit <= 3'd4) ? int'(check_bit) : 0;
    sb.push_back(f);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc);
    int n = 0;
    while ((sb.size() != 0 || mon_busy) && n < max_cyc) begin
      @(posedge clk); n++;
    end
    check("drain_in_time", int'(n < max_cyc), 1);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic release_break(input int d);
    int bad = 0;
    @(posedge clk); #1;
    brk = 1'b0;
    @(posedge clk);
    repeat (d) begin
      @(negedge clk);
      if (line !== 1'b1) bad++;
    end
    check("break_release_high", bad, 0);
    mon_break = 1'b0;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin : stim
    int n, bad;
    rst_n = 1'b0; brk = 1'b0; valid = 1'b0; tx_data = '0;
    set_cfg(4, 8, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_line", int'(line), 1);
    check("rst_ready", int'(ready), 1);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_level", int'(level), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8N1 0xA5, D=4, with start latency and busy rise
    push('hA5);
    check("latency_pre", int'(line), 1);
    @(posedge clk); #1;
    check("latency_start", int'(line), 0);
    check("busy_rise", int'(busy), 1);
    wait_drain(500);
    check("busy_fall", int'(busy), 0);

    // 7E1 and 7O1 with 0x83 (bit 7 ignored)
    set_cfg(4, 7, 0, 2); push('h83); wait_drain(500);
    set_cfg(4, 7, 0, 1); push('h83); wait_drain(500);
    // 8N1.5, D=5
    set_cfg(5, 8, 1, 0); push('h3C); wait_drain(500);

    // Randomised configurations and words
    for (int seg = 0; seg < 14; seg++) begin
      set_cfg($urandom_range(0, 6), $urandom_range(0, 15), $urandom_range(0, 3),
              $urandom_range(0, 7));
      n = $urandom_range(1, 4);
      for (int w = 0; w < n; w++) begin
        push($urandom_range(0, 511));
        repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      end
      wait_drain(3000);
    end

    // FIFO fill while stalled by break, then a rejected 9th write
    set_cfg(3, 8, 0, 0);
    brk = 1'b1; mon_break = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("break_line_low", int'(line), 0);
    check("break_busy", int'(busy), 1);
    for (int w = 0; w < 8; w++) push($urandom_range(0, 255));
    check("fill_level", int'(level), 8);
    check("fill_ready", int'(ready), 0);
    valid = 1'b1; tx_data = 9'h1AA;
    repeat (3) begin @(posedge clk); #1; end
    valid = 1'b0;
    check("ninth_rejected", int'(level), 8);
    contig = 0; done_cnt = 0;
    release_break(3);
    wait_drain(3000);
    check("fill_done_pulses", done_cnt, 8);
    check("fill_contiguous", contig, 7);

    // Break requested mid-frame: frame completes, break holds, queued word follows
    set_cfg(4, 8, 0, 0);
    done_cnt = 0;
    push($urandom_range(0, 255));
    repeat (12) begin @(posedge clk); #1; end
    brk = 1'b1; mon_break = 1'b1;
    push($urandom_range(0, 255));
    n = 0;
    while (done_cnt == 0 && n < 200) begin @(posedge clk); #1; n++; end
    check("break_frame_done", done_cnt, 1);
    repeat (3) begin @(posedge clk); #1; end
    bad = 0;
    repeat (12) begin
      @(negedge clk);
      if (line !== 1'b0) bad++;
    end
    check("break_hold_low", bad, 0);
    check("break_fifo_kept", int'(level), 1);
    release_break(4);
    wait_drain(1000);

    // Reset in the middle of DATA with one word still queued
    set_cfg(4, 8, 0, 0);
    push('h55);
    push('hAA);
    repeat (10) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    check("midrst_line", int'(line), 1);
    check("midrst_level", int'(level), 0);
    check("midrst_ready", int'(ready), 1);
    check("midrst_busy", int'(busy), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (60) begin @(posedge clk); #1; end
    check("midrst_no_done", done_cnt, 0);
    check("midrst_idle_line", int'(line), 1);
    push('h96);
    wait_drain(500);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
